// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from the VGA timing generator to the DAC and the pixel pipeline.
// The generator drives the master modport and downstream consumers use the slave modport.
interface vga_timing_gen_if;
    logic [9:0] x;
    logic [9:0] y;
    logic       pix_en;
    logic       vga_clk;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       sync_n;
    logic       frame_start;

    modport master (
        output x, y, pix_en, vga_clk, hsync, vsync, blank_n, sync_n, frame_start
    );

    modport slave (
        input  x, y, pix_en, vga_clk, hsync, vsync, blank_n, sync_n, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe at clk/2, x/y counters and horizontal/vertical phase FSMs.
// Sync and blank are registered from next-state decode, so they line up with the x/y being driven.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic clk,
    input  logic reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FRONT_START = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BACK_START  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FRONT_START = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BACK_START  = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FRONT  = 2'd1;
    localparam logic [1:0] ST_SYNC   = 2'd2;
    localparam logic [1:0] ST_BACK   = 2'd3;

    logic       phase;
    logic       pix_en_q;
    logic       vga_clk_q;
    logic [9:0] x_q, y_q, x_next, y_next;
    logic [1:0] hstate, vstate, hstate_next, vstate_next;
    logic       hsync_q, vsync_q, blank_q, frame_q;
    logic       seen_frame;
    logic       h_wrap, v_wrap;

    always_comb begin
        x_next = x_q;
        y_next = y_q;
        h_wrap = 1'b0;
        v_wrap = 1'b0;
        if (pix_en_q) begin
            if (x_q == H_LAST) begin
                x_next = 10'd0;
                h_wrap = 1'b1;
                if (y_q == V_LAST) begin
                    y_next = 10'd0;
                    v_wrap = 1'b1;
                end else begin
                    y_next = y_q + 10'd1;
                end
            end else begin
                x_next = x_q + 10'd1;
            end
        end
    end

    // Phase transitions key off the counter value about to be presented.
    always_comb begin
        hstate_next = hstate;
        case (hstate)
            ST_ACTIVE: if (x_next == H_FRONT_START) hstate_next = ST_FRONT;
            ST_FRONT:  if (x_next == H_SYNC_START)  hstate_next = ST_SYNC;
            ST_SYNC:   if (x_next == H_BACK_START)  hstate_next = ST_BACK;
            ST_BACK:   if (x_next == 10'd0)         hstate_next = ST_ACTIVE;
            default:                                hstate_next = ST_ACTIVE;
        endcase
    end

    always_comb begin
        vstate_next = vstate;
        if (h_wrap) begin
            case (vstate)
                ST_ACTIVE: if (y_next == V_FRONT_START) vstate_next = ST_FRONT;
                ST_FRONT:  if (y_next == V_SYNC_START)  vstate_next = ST_SYNC;
                ST_SYNC:   if (y_next == V_BACK_START)  vstate_next = ST_BACK;
                ST_BACK:   if (y_next == 10'd0)         vstate_next = ST_ACTIVE;
                default:                                vstate_next = ST_ACTIVE;
            endcase
        end
    end

    // phase is always the complement of pix_en, so vga_clk rises together with pix_en.
    // frame_start waits for a completed frame so the reset-held (0,0) never pulses it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= 1'b0;
            pix_en_q   <= 1'b0;
            vga_clk_q  <= 1'b0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            hstate     <= ST_ACTIVE;
            vstate     <= ST_ACTIVE;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            blank_q    <= 1'b1;
            frame_q    <= 1'b0;
            seen_frame <= 1'b0;
        end else begin
            phase      <= ~phase;
            pix_en_q   <= phase;
            vga_clk_q  <= phase;
            x_q        <= x_next;
            y_q        <= y_next;
            hstate     <= hstate_next;
            vstate     <= vstate_next;
            hsync_q    <= (hstate_next != ST_SYNC);
            vsync_q    <= (vstate_next != ST_SYNC);
            blank_q    <= (hstate_next == ST_ACTIVE) && (vstate_next == ST_ACTIVE);
            frame_q    <= phase && seen_frame && (x_q == 10'd0) && (y_q == 10'd0);
            if (v_wrap) begin
                seen_frame <= 1'b1;
            end
        end
    end

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.pix_en      = pix_en_q;
    assign vga.vga_clk     = vga_clk_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.blank_n     = blank_q;
    assign vga.sync_n      = 1'b0;
    assign vga.frame_start = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line timing and a shrunken instance for frame timing.
// A raster model indexed by clk edges since reset release feeds per-DUT scoreboard queues.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pix_en;
        logic       vga_clk;
        logic       hsync;
        logic       vsync;
        logic       blank_n;
        logic       sync_n;
        logic       frame_start;
    } vout_t;

    localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VA = 4, S_VF = 2, S_VS = 2, S_VB = 3;

    logic clk = 1'b0;
    logic reset_big = 1'b1;
    logic reset_small = 1'b1;
    int   kb = 0;
    int   ks = 0;
    int   checks = 0;
    int   passes = 0;
    vout_t sb_big[$];
    vout_t sb_small[$];

    always #10 clk = ~clk;

    vga_timing_gen_if big_if();
    vga_timing_gen_if small_if();

    vga_timing_gen u_big (.clk(clk), .reset(reset_big), .vga(big_if));

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_small (.clk(clk), .reset(reset_small), .vga(small_if));

    // Expected outputs after k clk edges since reset release (k=0 means held in reset).
    function automatic vout_t model(int k, int ha, int hf, int hs, int hb,
                                    int va, int vf, int vs, int vb);
        vout_t m;
        int ht, vt, p, xx, yy;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        p  = (k >= 1) ? (k - 1) / 2 : 0;
        xx = p % ht;
        yy = (p / ht) % vt;
        m.x           = 10'(xx);
        m.y           = 10'(yy);
        m.pix_en      = (k >= 1) && (k % 2 == 0);
        m.vga_clk     = m.pix_en;
        m.hsync       = !((xx >= ha + hf) && (xx < ha + hf + hs));
        m.vsync       = !((yy >= va + vf) && (yy < va + vf + vs));
        m.blank_n     = (xx < ha) && (yy < va);
        m.sync_n      = 1'b0;
        m.frame_start = m.pix_en && (p > 0) && (p % (ht * vt) == 0);
        return m;
    endfunction

    function automatic vout_t sample_big();
        vout_t s;
        s = {big_if.x, big_if.y, big_if.pix_en, big_if.vga_clk, big_if.hsync,
             big_if.vsync, big_if.blank_n, big_if.sync_n, big_if.frame_start};
        return s;
    endfunction

    function automatic vout_t sample_small();
        vout_t s;
        s = {small_if.x, small_if.y, small_if.pix_en, small_if.vga_clk, small_if.hsync,
             small_if.vsync, small_if.blank_n, small_if.sync_n, small_if.frame_start};
        return s;
    endfunction

    task automatic tick_big();
        @(posedge clk);
        if (!reset_big) kb++;
        sb_big.push_back(model(kb, 640, 16, 96, 48, 480, 10, 2, 33));
    endtask

    task automatic tick_small();
        @(posedge clk);
        if (!reset_small) ks++;
        sb_small.push_back(model(ks, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB));
    endtask

    task automatic test_reset();
        vout_t got, want;
        repeat (3) @(negedge clk);
        kb = 0;
        ks = 0;
        sb_big.push_back(model(0, 640, 16, 96, 48, 480, 10, 2, 33));
        want = sb_big.pop_front();
        got = sample_big();
        checks++;
        if (got !== want) $display("[TB] FAIL reset_big got=%h want=%h", got, want);
        else passes++;
        sb_small.push_back(model(0, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB));
        want = sb_small.pop_front();
        got = sample_small();
        checks++;
        if (got !== want) $display("[TB] FAIL reset_small got=%h want=%h", got, want);
        else passes++;
    endtask

    task automatic test_startup();
        vout_t got, want;
        logic [5:0] pat;
        pat = '0;
        reset_big = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick_big();
            @(negedge clk);
            want = sb_big.pop_front();
            got = sample_big();
            pat = {pat[4:0], got.pix_en};
            checks++;
            if (got !== want) $display("[TB] FAIL startup k=%0d got=%h want=%h", kb, got, want);
            else passes++;
        end
        checks++;
        if (pat !== 6'b010101) $display("[TB] FAIL startup_pix_en got=%b want=010101", pat);
        else passes++;
        checks++;
        if (got.x !== 10'd2 || got.y !== 10'd0 || got.blank_n !== 1'b1)
            $display("[TB] FAIL startup_xy got x=%0d y=%0d blank_n=%b want x=2 y=0 blank_n=1",
                     got.x, got.y, got.blank_n);
        else passes++;
    endtask

    task automatic test_hsync();
        vout_t got, want;
        int hs_low, bl_low, fall_x, rise_x;
        logic prev_hs;
        hs_low = 0; bl_low = 0; fall_x = -1; rise_x = -1; prev_hs = 1'b1;
        while (kb < 1600) begin
            tick_big();
            @(negedge clk);
            want = sb_big.pop_front();
            got = sample_big();
            checks++;
            if (got !== want) $display("[TB] FAIL line0 k=%0d got=%h want=%h", kb, got, want);
            else passes++;
            if (!got.hsync) hs_low++;
            if (!got.blank_n) bl_low++;
            if (prev_hs && !got.hsync) fall_x = int'(got.x);
            if (!prev_hs && got.hsync) rise_x = int'(got.x);
            prev_hs = got.hsync;
        end
        checks++;
        if (hs_low != 192) $display("[TB] FAIL hsync_width got=%0d want=192", hs_low);
        else passes++;
        checks++;
        if (fall_x != 656) $display("[TB] FAIL hsync_fall_x got=%0d want=656", fall_x);
        else passes++;
        checks++;
        if (rise_x != 752) $display("[TB] FAIL hsync_rise_x got=%0d want=752", rise_x);
        else passes++;
        checks++;
        if (bl_low != 320) $display("[TB] FAIL blank_width got=%0d want=320", bl_low);
        else passes++;
        checks++;
        if (got.x !== 10'd799 || got.y !== 10'd0 || got.blank_n !== 1'b0)
            $display("[TB] FAIL line_end got x=%0d y=%0d blank_n=%b want x=799 y=0 blank_n=0",
                     got.x, got.y, got.blank_n);
        else passes++;
    endtask

    task automatic test_line_wrap();
        vout_t got, want;
        while (kb < 1602) begin
            tick_big();
            @(negedge clk);
            want = sb_big.pop_front();
            got = sample_big();
            checks++;
            if (got !== want) $display("[TB] FAIL wrap k=%0d got=%h want=%h", kb, got, want);
            else passes++;
        end
        checks++;
        if (got.x !== 10'd0 || got.y !== 10'd1 || got.blank_n !== 1'b1)
            $display("[TB] FAIL line_wrap got x=%0d y=%0d blank_n=%b want x=0 y=1 blank_n=1",
                     got.x, got.y, got.blank_n);
        else passes++;
    endtask

    task automatic test_async_reset_big();
        vout_t got, want;
        int fs_seen;
        while (kb < 3001) begin
            tick_big();
            @(negedge clk);
            want = sb_big.pop_front();
            got = sample_big();
            checks++;
            if (got !== want) $display("[TB] FAIL line1 k=%0d got=%h want=%h", kb, got, want);
            else passes++;
        end
        checks++;
        if (got.x !== 10'd700 || got.y !== 10'd1)
            $display("[TB] FAIL pre_reset_big got x=%0d y=%0d want x=700 y=1", got.x, got.y);
        else passes++;
        #3 reset_big = 1'b1;
        kb = 0;
        #1;
        sb_big.push_back(model(0, 640, 16, 96, 48, 480, 10, 2, 33));
        want = sb_big.pop_front();
        got = sample_big();
        checks++;
        if (got !== want) $display("[TB] FAIL async_reset_big got=%h want=%h", got, want);
        else passes++;
        fs_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) reset_big = 1'b0;
            tick_big();
            @(negedge clk);
            want = sb_big.pop_front();
            got = sample_big();
            if (got.frame_start) fs_seen++;
            checks++;
            if (got !== want) $display("[TB] FAIL restart_big k=%0d got=%h want=%h", kb, got, want);
            else passes++;
        end
        checks++;
        if (fs_seen != 0) $display("[TB] FAIL restart_big_frame_start got=%0d want=0", fs_seen);
        else passes++;
    endtask

    task automatic test_frame();
        vout_t got, want;
        int fs_cnt, fs_first, vs_low, wrap_seen, prev_y;
        fs_cnt = 0; fs_first = -1; vs_low = 0; wrap_seen = 0; prev_y = 0;
        reset_small = 1'b0;
        while (ks < 664) begin
            tick_small();
            @(negedge clk);
            want = sb_small.pop_front();
            got = sample_small();
            checks++;
            if (got !== want) $display("[TB] FAIL frame k=%0d got=%h want=%h", ks, got, want);
            else passes++;
            if (got.frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = ks;
            end
            if (ks <= 330 && !got.vsync) vs_low++;
            if (prev_y == 10 && got.y == 10'd0) wrap_seen = 1;
            prev_y = int'(got.y);
        end
        checks++;
        if (fs_cnt != 2) $display("[TB] FAIL frame_start_count got=%0d want=2", fs_cnt);
        else passes++;
        checks++;
        if (fs_first != 332) $display("[TB] FAIL frame_start_edge got=%0d want=332", fs_first);
        else passes++;
        checks++;
        if (vs_low != 60) $display("[TB] FAIL vsync_width got=%0d want=60", vs_low);
        else passes++;
        checks++;
        if (wrap_seen != 1) $display("[TB] FAIL y_wrap got=%0d want=1", wrap_seen);
        else passes++;
    endtask

    task automatic test_async_reset_small();
        vout_t got, want;
        int fs_seen;
        while (ks < 893) begin
            tick_small();
            @(negedge clk);
            want = sb_small.pop_front();
            got = sample_small();
            checks++;
            if (got !== want) $display("[TB] FAIL frame3 k=%0d got=%h want=%h", ks, got, want);
            else passes++;
        end
        checks++;
        if (got.x !== 10'd11 || got.y !== 10'd7 || got.hsync !== 1'b0 || got.vsync !== 1'b0)
            $display("[TB] FAIL pre_reset_small got x=%0d y=%0d hs=%b vs=%b want x=11 y=7 hs=0 vs=0",
                     got.x, got.y, got.hsync, got.vsync);
        else passes++;
        #3 reset_small = 1'b1;
        ks = 0;
        #1;
        sb_small.push_back(model(0, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB));
        want = sb_small.pop_front();
        got = sample_small();
        checks++;
        if (got !== want) $display("[TB] FAIL async_reset_small got=%h want=%h", got, want);
        else passes++;
        fs_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) reset_small = 1'b0;
            tick_small();
            @(negedge clk);
            want = sb_small.pop_front();
            got = sample_small();
            if (got.frame_start) fs_seen++;
            checks++;
            if (got !== want) $display("[TB] FAIL restart_small k=%0d got=%h want=%h", ks, got, want);
            else passes++;
        end
        checks++;
        if (fs_seen != 0) $display("[TB] FAIL restart_small_frame_start got=%0d want=0", fs_seen);
        else passes++;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d passes=%0d", checks, passes);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_startup();
        test_hsync();
        test_line_wrap();
        test_async_reset_big();
        test_frame();
        test_async_reset_small();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line:
  H_ACTIVE 640, visible pixels per line
  H_FP 16, horizontal front porch pixels
  H_SYNC 96, horizontal sync width in pixels
  H_BP 48, horizontal back porch pixels
  V_ACTIVE 480, visible lines per frame
  V_FP 10, vertical front porch lines
  V_SYNC 2, vertical sync width in lines
  V_BP 33, vertical back porch lines
REQ-002 Ports SHALL be, one per line:
  clk  in  1  system clock, 50 MHz
  reset  in  1  asynchronous, active-high reset
  x  out  10  horizontal pixel counter, range 0..H_TOTAL-1
  y  out  10  vertical line counter, range 0..V_TOTAL-1
  pix_en  out  1  one-clk pixel strobe, high every 2nd clk
  vga_clk  out  1  25 MHz pixel clock to the DAC (clk/2)
  hsync  out  1  horizontal sync, active-low
  vsync  out  1  vertical sync, active-low
  blank_n  out  1  high while (x,y) is in the visible area
  sync_n  out  1  DAC composite sync, tied to 0
  frame_start  out  1  one-clk pulse at the start of a frame
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-high, on ports clk and reset.
REQ-004 Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).

Function
REQ-005 pix_en toggles every clk: 0,1,0,1 after reset release. vga_clk = registered inverse of pix_en, so vga_clk rises on the edge where pix_en rises.
REQ-006 x, y SHALL advance only on clk edges where pix_en=1; otherwise hold.
REQ-007 x increments by 1; at H_TOTAL-1 it wraps to 0 and y increments by 1 in the same edge.
REQ-008 y at V_TOTAL-1, when x wraps, SHALL wrap to 0; x and y never exceed H_TOTAL-1 / V_TOTAL-1.
REQ-009 Horizontal phase FSM: ACTIVE (x<640) -> FRONT (640..655) -> SYNC (656..751) -> BACK (752..799) -> ACTIVE. State changes only on pix_en edges, in lockstep with x.
REQ-010 Vertical phase FSM: ACTIVE (y<480) -> FRONT (480..489) -> SYNC (490..491) -> BACK (492..524) -> ACTIVE. Advances only on horizontal wrap.
REQ-011 hsync=0 exactly while the horizontal FSM is in SYNC; vsync=0 exactly while the vertical FSM is in SYNC.
REQ-012 blank_n=1 exactly while both FSMs are in ACTIVE.
REQ-013 hsync, vsync, blank_n and frame_start SHALL be registered and describe the x,y currently driven, with no skew: they are decoded from next-state values.
REQ-014 frame_start=1 for exactly one clk, on the pix_en=1 cycle in which x=0 and y=0 is presented. Downstream address counters clear on this point.
REQ-015 sync_n SHALL be constant 0.
REQ-016 A line is 800 pixel periods (1600 clk); a frame is 420000 pixel periods (840000 clk).

Reset
REQ-017 While reset=1, outputs SHALL be: x=0, y=0, pix_en=0, vga_clk=0, hsync=1, vsync=1, blank_n=1, frame_start=0; both FSMs in ACTIVE.
REQ-018 Assertion SHALL take effect immediately, including mid-line or mid-sync; outputs reach reset values without waiting for clk.
REQ-019 After release, the first pix_en=1 occurs on the 2nd clk edge; frame_start SHALL NOT pulse for the reset-held (0,0).
REQ-020 The first frame_start SHALL occur after the first full frame wraps.

Verification
REQ-021 Release reset, run 6 clk -> pix_en 0,1,0,1,0,1; x steps 0->1->2 only on pix_en edges; y=0; blank_n=1.
REQ-022 Run to x=655 -> 656 -> hsync falls as x reads 656; hsync rises as x reads 752; hsync is low for 96 pixels (192 clk).
REQ-023 Run to x=799, y=0 -> next pix_en edge gives x=0, y=1; blank_n is 0 for x=640..799 and 1 again at x=0.
REQ-024 Run a full frame -> vsync low only for y=490..491 (1600 pixel periods); y wraps 524->0; frame_start pulses once, 840000 clk after the first pix_en.
REQ-025 Assert reset asynchronously at x=700, y=491, between clk edges -> all outputs return immediately to REQ-017 values; after release the sequence restarts per REQ-019.
REQ-026 Check every clk that blank_n, hsync and vsync agree with REQ-011/012 decode of current x,y; mismatches are failures.
